// File: rtl/div_32_bit_if.sv
// Operand/result bundle between the execute stage and the multi-cycle divider.
// The pipeline drives the master side; the divider is the slave.
interface div_32_bit_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output data_operandA,
      output data_operandB,
      output ctrl_DIV,
      input  data_result,
      input  data_exception,
      input  data_resultRDY
   );

   modport slave (
      input  data_operandA,
      input  data_operandB,
      input  ctrl_DIV,
      output data_result,
      output data_exception,
      output data_resultRDY
   );
endinterface

// File: rtl/div_32_bit.sv
// Restoring signed divider: magnitudes are divided one quotient bit per cycle,
// then the sign is applied in a single FIX cycle that also raises the ready strobe.
module div_32_bit #(
   parameter int WIDTH = 32
) (
   input logic         clock,
   input logic         reset,
   div_32_bit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      if (v[WIDTH-1]) begin
         abs_val = ~v + ONE;
      end else begin
         abs_val = v;
      end
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [5:0]       cnt_q, cnt_d;
   logic             sign_q, sign_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic [WIDTH:0]   rem_shift_s;
   logic [WIDTH:0]   trial_s;

   assign rem_shift_s = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign trial_s     = rem_shift_s - {1'b0, div_q};

   // Next-state logic: a start pulse in any state relatches operands and restarts.
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      div_d    = div_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      dz_d     = dz_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;

      if (bus.ctrl_DIV) begin
         q_d     = abs_val(bus.data_operandA);
         div_d   = abs_val(bus.data_operandB);
         sign_d  = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         dz_d    = (bus.data_operandB == ZERO);
         rem_d   = {1'b0, ZERO};
         cnt_d   = 6'd0;
         state_d = ITER;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            ITER: begin
               // A clear borrow bit means the divisor fit: keep the difference.
               q_d   = {q_q[WIDTH-2:0], ~trial_s[WIDTH]};
               rem_d = trial_s[WIDTH] ? rem_shift_s : trial_s;
               if (cnt_q == 6'd31) begin
                  cnt_d   = 6'd0;
                  state_d = FIX;
               end else begin
                  cnt_d   = cnt_q + 6'd1;
                  state_d = ITER;
               end
            end
            FIX: begin
               if (dz_q) begin
                  result_d = ZERO;
               end else if (sign_q) begin
                  result_d = ~q_q + ONE;
               end else begin
                  result_d = q_q;
               end
               exc_d   = dz_q;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset taking priority over start.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         q_q      <= ZERO;
         div_q    <= ZERO;
         rem_q    <= {1'b0, ZERO};
         cnt_q    <= 6'd0;
         sign_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= ZERO;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         dz_q     <= dz_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;

endmodule
